uart_receiver_param: RTL and testbench

Parametrised, oversampling UART receiver, successor to the fixed 8-bit receiver. It has configurable data width, runtime-selectable parity (none/even/odd) and 1 or 2 stop bits. Each bit is decided by a 3-sample majority vote, and it adds break detection and a read handshake with overrun reporting. It sits between the RxD pin and the host register interface and contains its own baud-tick generator.

---
 rtl/uart_receiver_param.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_uart_receiver_param.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver_param.sv
// -----------------------------------------------------------------------------
// uart_receiver_param
// Oversampling UART receiver with configurable data width, runtime-selectable
// parity (none/even/odd), one or two stop bits, 3-sample majority voting per
// bit, break detection and a read handshake with overrun reporting. Contains
// its own baud-tick generator.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-low reset
//   baud_select    0=300 1=1200 2=4800 3=9600 4=19200 5=38400 6=57600 7=115200
//   Rx_EN          receiver enable; dropping it mid-frame discards the frame
//   Rx_PARITY_MODE 00/11=none, 01=even, 10=odd (sampled at frame start)
//   Rx_STOP2       1 = two stop bits expected (sampled at frame start)
//   RxD            asynchronous serial line, idle high
//   Rx_RD          one-cycle read strobe, clears Rx_VALID
//   Rx_DATA        payload of the last good frame
//   Rx_VALID       high while an unread good frame is held
//   Rx_FERROR      one-cycle pulse: framing error
//   Rx_PERROR      one-cycle pulse: parity error
//   Rx_OERROR      one-cycle pulse: good frame lost because Rx_VALID was set
//   Rx_BREAK       one-cycle pulse: break frame (all zeros, low stop bit)
// -----------------------------------------------------------------------------
module uart_receiver_param #(
    parameter int CLK_HZ     = 50000000,
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        baud_select,
    input  logic              Rx_EN,
    input  logic [1:0]        Rx_PARITY_MODE,
    input  logic              Rx_STOP2,
    input  logic              RxD,
    input  logic              Rx_RD,
    output logic [DATA_W-1:0] Rx_DATA,
    output logic              Rx_VALID,
    output logic              Rx_FERROR,
    output logic              Rx_PERROR,
    output logic              Rx_OERROR,
    output logic              Rx_BREAK
);

    localparam int M  = OVERSAMPLE / 2;
    localparam int SW = $clog2(OVERSAMPLE);

    localparam logic [SW-1:0] S_PRE  = SW'(M - 1);
    localparam logic [SW-1:0] S_MID  = SW'(M);
    localparam logic [SW-1:0] S_DEC  = SW'(M + 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [3:0]    LAST_BIT = 4'(DATA_W - 1);

    // Rounded clock divisor for one oversample tick at the given baud rate.
    function automatic logic [15:0] calc_div(input longint baud);
        longint den;
        den = baud * longint'(OVERSAMPLE);
        return 16'((longint'(CLK_HZ) + den / 2) / den);
    endfunction

    localparam logic [15:0] DIV0 = calc_div(300);
    localparam logic [15:0] DIV1 = calc_div(1200);
    localparam logic [15:0] DIV2 = calc_div(4800);
    localparam logic [15:0] DIV3 = calc_div(9600);
    localparam logic [15:0] DIV4 = calc_div(19200);
    localparam logic [15:0] DIV5 = calc_div(38400);
    localparam logic [15:0] DIV6 = calc_div(57600);
    localparam logic [15:0] DIV7 = calc_div(115200);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP1, STOP2, DONE
    } state_t;

    state_t            state, nxt_state;
    logic [1:0]        sync_q;
    logic              rx_s, rx_prev;
    logic [15:0]       div_val, div_cnt;
    logic              tick, start_edge, at_dec, at_end, maj;
    logic [SW-1:0]     s_cnt;
    logic              samp_a, samp_b;
    logic [DATA_W-1:0] shadow;
    logic [3:0]        bit_idx;
    logic [1:0]        par_mode_q;
    logic              stop2_q, ferr, perr, par_bit, stop_low, brk_hold;
    logic              parity_en, par_exp;
    logic              do_break, do_ferr, do_perr, do_oerr, do_load;

    always_comb begin
        case (baud_select)
            3'd0:    div_val = DIV0;
            3'd1:    div_val = DIV1;
            3'd2:    div_val = DIV2;
            3'd3:    div_val = DIV3;
            3'd4:    div_val = DIV4;
            3'd5:    div_val = DIV5;
            3'd6:    div_val = DIV6;
            default: div_val = DIV7;
        endcase
    end

    assign rx_s       = sync_q[1];
    // >= so a baud change mid-count cannot leave the divider running past its wrap.
    assign tick       = Rx_EN && (div_cnt >= div_val - 16'd1);
    assign start_edge = Rx_EN && (state == IDLE) && !brk_hold && rx_prev && !rx_s;
    assign at_dec     = tick && (s_cnt == S_DEC);
    assign at_end     = tick && (s_cnt == S_LAST);
    // samp_a/samp_b hold samples M-1 and M; the live line is sample M+1.
    assign maj        = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
    assign parity_en  = (par_mode_q == 2'b01) || (par_mode_q == 2'b10);
    assign par_exp    = (par_mode_q == 2'b10) ? ~^shadow : ^shadow;

    // Synchroniser, edge history and baud divider. The divider restarts on the
    // start edge so sample ticks line up with the frame's bit boundaries.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= 2'b11;
            rx_prev <= 1'b1;
            div_cnt <= '0;
        end else begin
            sync_q  <= {sync_q[0], RxD};
            rx_prev <= rx_s;
            if (!Rx_EN || start_edge || tick)
                div_cnt <= '0;
            else
                div_cnt <= div_cnt + 16'd1;
        end
    end

    // Sample index within the bit. In IDLE it only runs during break hold-off,
    // where it measures how long the line has been continuously high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_cnt    <= '0;
            brk_hold <= 1'b0;
        end else begin
            if (state == IDLE) begin
                if (!brk_hold || !rx_s)
                    s_cnt <= '0;
                else if (tick)
                    s_cnt <= (s_cnt == S_LAST) ? '0 : s_cnt + SW'(1);
            end else if (tick) begin
                s_cnt <= (s_cnt == S_LAST) ? '0 : s_cnt + SW'(1);
            end

            if (do_break)
                brk_hold <= 1'b1;
            else if (state == IDLE && brk_hold && rx_s && at_end)
                brk_hold <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        if (!Rx_EN) begin
            nxt_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_edge) nxt_state = START;
                START: begin
                    if (at_dec && maj)
                        nxt_state = IDLE;
                    else if (at_end)
                        nxt_state = DATA;
                end
                DATA:    if (at_end && bit_idx == LAST_BIT)
                             nxt_state = parity_en ? PARITY : STOP1;
                PARITY:  if (at_end) nxt_state = STOP1;
                // The final stop bit ends at its majority decision so the
                // receiver is ready for a start edge in the second half-bit.
                STOP1: begin
                    if (stop2_q) begin
                        if (at_end) nxt_state = STOP2;
                    end else if (at_dec) begin
                        nxt_state = DONE;
                    end
                end
                STOP2:   if (at_dec) nxt_state = DONE;
                DONE:    nxt_state = IDLE;
                default: nxt_state = IDLE;
            endcase
        end
    end

    // Frame resolution in DONE, highest priority first.
    always_comb begin
        do_break = 1'b0;
        do_ferr  = 1'b0;
        do_perr  = 1'b0;
        do_oerr  = 1'b0;
        do_load  = 1'b0;
        if (state == DONE && Rx_EN) begin
            if (shadow == '0 && !par_bit && stop_low) begin
                do_break = 1'b1;
            end else if (ferr || perr) begin
                do_ferr = ferr;
                do_perr = perr;
            end else if (Rx_VALID && !Rx_RD) begin
                do_oerr = 1'b1;
            end else begin
                do_load = 1'b1;
            end
        end
    end

    // Per-frame datapath: majority samples, shift register and error flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            samp_a     <= 1'b1;
            samp_b     <= 1'b1;
            shadow     <= '0;
            bit_idx    <= '0;
            par_mode_q <= 2'b00;
            stop2_q    <= 1'b0;
            ferr       <= 1'b0;
            perr       <= 1'b0;
            par_bit    <= 1'b0;
            stop_low   <= 1'b0;
        end else begin
            if (tick && s_cnt == S_PRE) samp_a <= rx_s;
            if (tick && s_cnt == S_MID) samp_b <= rx_s;
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        par_mode_q <= Rx_PARITY_MODE;
                        stop2_q    <= Rx_STOP2;
                        bit_idx    <= '0;
                        ferr       <= 1'b0;
                        perr       <= 1'b0;
                        par_bit    <= 1'b0;
                        stop_low   <= 1'b0;
                    end
                end
                DATA: begin
                    if (at_dec) shadow  <= {maj, shadow[DATA_W-1:1]};
                    if (at_end) bit_idx <= bit_idx + 4'd1;
                end
                PARITY: begin
                    if (at_dec) begin
                        par_bit <= maj;
                        perr    <= (maj != par_exp);
                    end
                end
                STOP1: begin
                    if (at_dec) begin
                        stop_low <= ~maj;
                        if (!maj) ferr <= 1'b1;
                    end
                end
                STOP2: begin
                    if (at_dec && !maj) ferr <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Rx_DATA   <= '0;
            Rx_VALID  <= 1'b0;
            Rx_FERROR <= 1'b0;
            Rx_PERROR <= 1'b0;
            Rx_OERROR <= 1'b0;
            Rx_BREAK  <= 1'b0;
        end else begin
            Rx_FERROR <= do_ferr;
            Rx_PERROR <= do_perr;
            Rx_OERROR <= do_oerr;
            Rx_BREAK  <= do_break;
            if (do_load) begin
                Rx_DATA  <= shadow;
                Rx_VALID <= 1'b1;
            end else if (Rx_RD) begin
                Rx_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver_param.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver_param
// Scoreboard bench for uart_receiver_param at 50 MHz / 115200 baud (27 clk per
// sample tick, 432 clk per bit). Each frame sent pushes its expected outcome;
// a monitor pops and compares whenever the receiver reports an event.
// -----------------------------------------------------------------------------
module tb_uart_receiver_param;

    localparam int DATA_W  = 8;
    localparam int BIT_CLK = 27 * 16;
    localparam int GAP_CLK = 40;

    // kind bits: [4]=break [3]=ferror [2]=perror [1]=oerror [0]=new good data
    typedef struct {
        logic [4:0]        kind;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t exp_q[$];

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [2:0]        baud_select = 3'd7;
    logic              Rx_EN = 1'b1;
    logic [1:0]        Rx_PARITY_MODE = 2'b00;
    logic              Rx_STOP2 = 1'b0;
    logic              RxD = 1'b1;
    logic              Rx_RD = 1'b0;
    logic [DATA_W-1:0] Rx_DATA;
    logic              Rx_VALID, Rx_FERROR, Rx_PERROR, Rx_OERROR, Rx_BREAK;

    int n_checks = 0;
    int n_fail   = 0;

    logic              model_valid = 1'b0;
    logic [DATA_W-1:0] model_data  = '0;

    always #10 clk = ~clk;

    uart_receiver_param #(
        .CLK_HZ(50000000),
        .DATA_W(DATA_W),
        .OVERSAMPLE(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .baud_select(baud_select),
        .Rx_EN(Rx_EN),
        .Rx_PARITY_MODE(Rx_PARITY_MODE),
        .Rx_STOP2(Rx_STOP2),
        .RxD(RxD),
        .Rx_RD(Rx_RD),
        .Rx_DATA(Rx_DATA),
        .Rx_VALID(Rx_VALID),
        .Rx_FERROR(Rx_FERROR),
        .Rx_PERROR(Rx_PERROR),
        .Rx_OERROR(Rx_OERROR),
        .Rx_BREAK(Rx_BREAK)
    );

    // Monitor: any error pulse or a rising Rx_VALID is one receiver event.
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        logic [4:0] seen;
        exp_t       e;
        if (!reset) begin
            prev_valid = 1'b0;
        end else begin
            seen = {Rx_BREAK, Rx_FERROR, Rx_PERROR, Rx_OERROR, Rx_VALID & ~prev_valid};
            prev_valid = Rx_VALID;
            if (seen != 5'b0) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL unexpected_event: got kind=%b data=%h, required no event",
                             seen, Rx_DATA);
                end else begin
                    e = exp_q.pop_front();
                    if (seen !== e.kind || Rx_DATA !== e.data) begin
                        n_fail++;
                        $display("[TB] FAIL event: got kind=%b data=%h, required kind=%b data=%h",
                                 seen, Rx_DATA, e.kind, e.data);
                    end
                end
            end
        end
    end

    // Sends one frame. mode: 0 = normal (expectation pushed), 1 = Rx_EN dropped
    // during data bits 2..4 (frame discarded), 2 = frame expected to be ignored.
    task automatic applyStimulus(input logic [DATA_W-1:0] data, input logic [1:0] pmode,
                                 input logic stop2, input logic flip_par,
                                 input logic [1:0] stop_bits, input int glitch_bit,
                                 input int mode);
        logic q[$];
        logic par_en, par_val, brk, fe, pe;
        exp_t e;
        par_en  = (pmode == 2'b01) || (pmode == 2'b10);
        par_val = (($countones(data) % 2) == 1) ^ (pmode == 2'b10) ^ flip_par;
        if (mode == 0) begin
            brk = (data == '0) && (!par_en || !par_val) && !stop_bits[0];
            fe  = !stop_bits[0] || (stop2 && !stop_bits[1]);
            pe  = par_en && flip_par;
            if (brk) begin
                e.kind = 5'b10000;
            end else if (fe || pe) begin
                e.kind = {1'b0, fe, pe, 2'b00};
            end else if (model_valid) begin
                e.kind = 5'b00010;
            end else begin
                e.kind      = 5'b00001;
                model_valid = 1'b1;
                model_data  = data;
            end
            e.data = model_data;
            exp_q.push_back(e);
        end
        q.push_back(1'b0);
        for (int b = 0; b < DATA_W; b++) q.push_back(data[b]);
        if (par_en) q.push_back(par_val);
        q.push_back(stop_bits[0]);
        if (stop2) q.push_back(stop_bits[1]);
        @(posedge clk);
        #1;
        Rx_PARITY_MODE = pmode;
        Rx_STOP2       = stop2;
        for (int i = 0; i < q.size(); i++) begin
            for (int c = 0; c < BIT_CLK; c++) begin
                @(posedge clk);
                #1;
                RxD = q[i] ^ ((i == glitch_bit + 1) && c >= 205 && c < 230);
                if (mode == 1 && c == 0 && i == 3) Rx_EN = 1'b0;
                if (mode == 1 && c == 0 && i == 6) Rx_EN = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        RxD = 1'b1;
        repeat (GAP_CLK) @(posedge clk);
    endtask

    // Waits (bounded) for all expected events, then checks the held state.
    task automatic checkOutput(input string name);
        int waited = 0;
        while (exp_q.size() != 0 && waited < 2 * BIT_CLK) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL %s_timeout: %0d events pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        n_checks++;
        if (Rx_VALID !== model_valid || Rx_DATA !== model_data) begin
            n_fail++;
            $display("[TB] FAIL %s_state: got valid=%b data=%h, required valid=%b data=%h",
                     name, Rx_VALID, Rx_DATA, model_valid, model_data);
        end
    endtask

    task automatic readData();
        @(posedge clk);
        #1 Rx_RD = 1'b1;
        @(posedge clk);
        #1 Rx_RD = 1'b0;
        model_valid = 1'b0;
        n_checks++;
        if (Rx_VALID !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL read_clear: got valid=%b, required 0", Rx_VALID);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [DATA_W-1:0] rdata;
        logic [1:0]        rpm, rstop;
        logic              rs2, rflip;

        repeat (5) @(negedge clk);
        n_checks++;
        if ({Rx_DATA, Rx_VALID, Rx_FERROR, Rx_PERROR, Rx_OERROR, Rx_BREAK} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_state: got data=%h valid=%b flags=%b%b%b%b, required all 0",
                     Rx_DATA, Rx_VALID, Rx_FERROR, Rx_PERROR, Rx_OERROR, Rx_BREAK);
        end
        #1 reset = 1'b1;
        repeat (20) @(posedge clk);

        applyStimulus(8'hA5, 2'b00, 1'b0, 1'b0, 2'b11, -1, 0);
        checkOutput("good_a5");
        readData();

        applyStimulus(8'h3C, 2'b01, 1'b0, 1'b1, 2'b11, -1, 0);
        checkOutput("perr_3c");

        applyStimulus(8'h55, 2'b00, 1'b1, 1'b0, 2'b01, -1, 0);
        checkOutput("ferr_stop2");

        applyStimulus(8'h55, 2'b00, 1'b1, 1'b0, 2'b11, 3, 0);
        checkOutput("glitch_55");
        readData();

        applyStimulus(8'h11, 2'b00, 1'b0, 1'b0, 2'b11, -1, 0);
        applyStimulus(8'h22, 2'b00, 1'b0, 1'b0, 2'b11, -1, 0);
        checkOutput("overrun");
        readData();

        // Break: line low for 12 bit times, then a frame whose only falling
        // edge arrives during hold-off must be ignored.
        begin
            exp_t e;
            e.kind = 5'b10000;
            e.data = model_data;
            exp_q.push_back(e);
        end
        Rx_PARITY_MODE = 2'b00;
        Rx_STOP2       = 1'b0;
        RxD = 1'b0;
        repeat (12 * BIT_CLK) @(posedge clk);
        #1 RxD = 1'b1;
        repeat (BIT_CLK / 2) @(posedge clk);
        applyStimulus(8'hFF, 2'b00, 1'b0, 1'b0, 2'b11, -1, 2);
        checkOutput("break");

        @(posedge clk);
        #1 RxD = 1'b0;
        repeat (4) @(posedge clk);
        #1 RxD = 1'b1;
        repeat (BIT_CLK + GAP_CLK) @(posedge clk);
        checkOutput("false_start");

        applyStimulus(8'hF0, 2'b00, 1'b0, 1'b0, 2'b11, -1, 1);
        checkOutput("en_drop");

        for (int k = 0; k < 3; k++) begin
            rdata = DATA_W'($urandom_range(1, 255));
            rpm   = 2'($urandom_range(0, 3));
            rs2   = 1'($urandom_range(0, 1));
            rflip = ($urandom_range(0, 3) == 0);
            rstop = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
            if ($urandom_range(0, 1) == 1) readData();
            applyStimulus(rdata, rpm, rs2, rflip, rstop, -1, 0);
            checkOutput("random");
        end

        readData();
        applyStimulus(8'h96, 2'b00, 1'b0, 1'b0, 2'b11, -1, 0);
        checkOutput("good_96");

        // Reset in the middle of a frame clears every output at once.
        @(posedge clk);
        #1 RxD = 1'b0;
        repeat (3 * BIT_CLK) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        model_valid = 1'b0;
        model_data  = '0;
        n_checks++;
        if ({Rx_DATA, Rx_VALID, Rx_FERROR, Rx_PERROR, Rx_OERROR, Rx_BREAK} !== '0) begin
            n_fail++;
            $display("[TB] FAIL midframe_reset: got data=%h valid=%b, required all outputs 0",
                     Rx_DATA, Rx_VALID);
        end
        RxD = 1'b1;
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        repeat (BIT_CLK) @(posedge clk);
        checkOutput("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
